// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that shares a 16:1 single-bit mux among 16 requesters
//
// Grants one requester at a time for a burst of up to MAX_BURST cycles. It drives the mux
// selector and captures the mux output as a tagged sample stream.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   req[15:0]    - request per requester (bit i requests mux input i)
//   mux_out      - combinational output of the mux addressed by sel
//   sel[3:0]     - registered mux selector
//   gnt[15:0]    - registered one-hot grant, zero when no grant is active
//   busy         - high while a grant is active (state GRANT)
//   sample_valid - one-cycle strobe qualifying sample_data / sample_src
//   sample_data  - captured mux_out
//   sample_src   - index of the requester whose bit was captured
module mux_rr_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        mux_out,
   output logic [3:0]  sel,
   output logic [15:0] gnt,
   output logic        busy,
   output logic        sample_valid,
   output logic        sample_data,
   output logic [3:0]  sample_src
);

   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t        state, state_nx;
   logic [3:0]    ptr, win;
   logic [CW-1:0] cnt;
   logic          take, done;

   // Scan downward in priority so the requester closest to ptr (offset 0) is assigned last and wins.
   always_comb begin
      win = ptr;
      for (int i = 15; i >= 0; i--)
         if (req[ptr + 4'(i)]) win = ptr + 4'(i);
   end

   // A dropped request ends the burst without a sample, even on the burst-limit cycle.
   assign take = (state == GRANT) && req[sel];
   assign done = !req[sel] || (cnt == CW'(MAX_BURST));
   assign busy = (state == GRANT);

   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE)  ? (|req ? GRANT : IDLE) :
                 (state == GRANT) ? (done ? GAP : GRANT)  : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel          <= '0;
         gnt          <= '0;
         ptr          <= '0;
         cnt          <= '0;
         sample_valid <= 1'b0;
         sample_data  <= 1'b0;
         sample_src   <= '0;
      end else begin
         sample_valid <= take;
         if (take) begin
            sample_data <= mux_out;
            sample_src  <= sel;
         end
         if (state == IDLE && |req) begin
            sel <= win;
            gnt <= 16'd1 << win;
            cnt <= CW'(1);
         end
         if (state == GRANT) begin
            if (done) begin
               gnt <= '0;
               ptr <= sel + 4'd1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: self-checking bench for mux_rr_arbiter with a behavioural model and directed plus random stimulus
module tb_mux_rr_arbiter;

   localparam int MB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic [15:0] rnd_data = '0;
   logic        walk = 1'b0;
   logic [15:0] mux_data;
   logic        mux_out;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        busy, sample_valid, sample_data;
   logic [3:0]  sample_src;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Mux model: in walk mode only the selected input carries a 1.
   assign mux_data = walk ? (16'd1 << sel) : rnd_data;
   assign mux_out  = mux_data[sel];

   mux_rr_arbiter #(.MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .mux_out(mux_out),
      .sel(sel), .gnt(gnt), .busy(busy), .sample_valid(sample_valid),
      .sample_data(sample_data), .sample_src(sample_src)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: phase 0 = waiting, 1 = serving owner, 2 = dead cycle.
   int         m_phase, m_owner, m_next, m_used;
   logic [15:0] m_gnt;
   logic       m_sv, m_sd;
   int         m_ss;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_owner = 0; m_next = 0; m_used = 0;
         m_gnt = '0; m_sv = 1'b0; m_sd = 1'b0; m_ss = 0;
      end else begin
         m_sv = (m_phase == 1) && req[m_owner];
         if (m_sv) begin
            m_sd = walk ? 1'b1 : rnd_data[m_owner];
            m_ss = m_owner;
         end
         if (m_phase == 0) begin
            if (req != 0) begin
               for (int k = 15; k >= 0; k--)
                  if (req[(m_next + k) % 16]) m_owner = (m_next + k) % 16;
               m_gnt = 16'd1 << m_owner;
               m_used = 1;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (!req[m_owner] || m_used == MB) begin
               m_gnt = '0;
               m_next = (m_owner + 1) % 16;
               m_phase = 2;
            end else begin
               m_used++;
            end
         end else begin
            m_phase = 0;
         end
      end
   end

   int          sq_src[$];
   int          sq_dat[$];
   int          gq[$];
   logic [15:0] prev_gnt = '0;

   always @(negedge clk) begin
      chk("sel", 32'(sel), 32'(m_owner));
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("sample_valid", 32'(sample_valid), 32'(m_sv));
      chk("sample_data", 32'(sample_data), 32'(m_sd));
      chk("sample_src", 32'(sample_src), 32'(m_ss));
      if (sample_valid) begin
         sq_src.push_back(int'(sample_src));
         sq_dat.push_back(int'(sample_data));
      end
      if (gnt != 0 && prev_gnt == 0)
         for (int i = 0; i < 16; i++) if (gnt[i]) gq.push_back(i);
      prev_gnt = gnt;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear_logs();
      sq_src.delete();
      sq_dat.delete();
      gq.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   int exp_order[6] = '{0, 1, 15, 0, 1, 15};

   initial begin
      // Reset and idle
      do_reset();
      repeat (10) begin
         @(negedge clk);
         chk("idle_outputs", {sel, gnt, busy, sample_valid, sample_data, sample_src}, 32'd0);
      end
      cyc(1);

      // Single burst with mux output tied high
      rnd_data = 16'hFFFF;
      clear_logs();
      req = 16'h0001;
      cyc(5);
      req = '0;
      cyc(3);
      chk("single_nsamples", sq_src.size(), 4);
      for (int i = 0; i < sq_src.size(); i++) begin
         chk("single_src", sq_src[i], 0);
         chk("single_dat", sq_dat[i], 1);
      end
      chk("single_ngrants", gq.size(), 1);
      req = 16'h0003;
      cyc(2);
      chk("single_ptr_next", 32'(gnt), 32'h0002);
      req = '0;
      cyc(8);

      // Round-robin wrap
      do_reset();
      clear_logs();
      req = 16'h8003;
      cyc(40);
      req = '0;
      cyc(8);
      chk("rr_ngrants_min", 32'(gq.size() >= 6), 32'd1);
      for (int i = 0; i < 6 && i < gq.size(); i++) chk("rr_order", gq[i], exp_order[i]);
      for (int i = 0; i < 24 && i < sq_src.size(); i++) chk("rr_sample_src", sq_src[i], exp_order[i / 4]);

      // Early drop in the second grant cycle
      do_reset();
      clear_logs();
      req = 16'h0020;
      cyc(2);
      req = '0;
      cyc(3);
      chk("drop_nsamples", sq_src.size(), 1);
      if (sq_src.size() > 0) chk("drop_src", sq_src[0], 5);
      req = 16'h0041;
      cyc(2);
      chk("drop_ptr_next", 32'(gnt), 32'h0040);
      req = '0;
      cyc(8);

      // Mux datapath one-hot walk
      do_reset();
      clear_logs();
      walk = 1'b1;
      req = 16'hFFFF;
      cyc(100);
      req = '0;
      cyc(8);
      walk = 1'b0;
      chk("walk_nsamples", 32'(sq_src.size() >= 64), 32'd1);
      for (int i = 0; i < 64 && i < sq_src.size(); i++) begin
         chk("walk_src", sq_src[i], i / 4);
         chk("walk_dat", sq_dat[i], 1);
      end

      // Reset in the third grant cycle of requester 7
      do_reset();
      req = 16'h0080;
      cyc(3);
      chk("midrst_gnt_before", 32'(gnt), 32'h0080);
      rst_n = 1'b0;
      #1;
      chk("midrst_clear", {sel, gnt, busy, sample_valid}, 32'd0);
      req = 16'h0081;
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      chk("midrst_first_gnt", 32'(gnt), 32'h0001);
      req = '0;
      cyc(8);

      // Random stimulus against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0)
            req = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
         rnd_data = 16'($urandom);
         rst_n = ($urandom_range(0, 599) != 0);
         cyc(1);
      end
      rst_n = 1'b1;
      cyc(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer that shares the 16:1 single-bit mux (`sixteenToOne`) among 16 requesters. It drives the mux selector and a one-hot grant, and holds each grant for a bounded burst. It captures the mux output every granted cycle and presents it downstream as a tagged sample stream. It sits between the requester bank driving the mux `data` bus and the single consumer of the mux `out` bit.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum consecutive granted cycles per requester. Legal range is 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  16  request per requester; bit i requests mux input i.
- `mux_out`  in  1  combinational `out` of the 16:1 mux, whose selector is driven by `sel`.
- `sel`  out  4  mux selector (registered).
- `gnt`  out  16  one-hot grant (registered); all-zero when no grant is active.
- `busy`  out  1  high while in GRANT.
- `sample_valid`  out  1  one-cycle strobe: `sample_data` and `sample_src` are valid.
- `sample_data`  out  1  captured `mux_out`.
- `sample_src`  out  4  index of the requester whose bit was captured.

## Operation
- FSM states: IDLE, GRANT, GAP.
- Internal state:
  - `ptr` (4 bits): highest-priority candidate.
  - `cnt`: burst counter, width `$clog2(MAX_BURST+1)`.
- Arbitration rule:
  - Winner is the first set bit of `req` scanning upward from `ptr`, wrapping 15 -> 0.
  - With `ptr`=14, the scan order is 14, 15, 0, 1, …, 13.
- IDLE:
  - If `req` is all-zero, stay; `gnt`=0, `sel` holds its last value.
  - Otherwise register `sel`=winner, `gnt`=1<<winner, `cnt`=1, then go to GRANT.
- GRANT, each cycle:
  - If `req[sel]`=1: capture `mux_out` into `sample_data` and `sel` into `sample_src`, and assert `sample_valid` on the next cycle.
  - Exit to GAP when `req[sel]`=0 (no sample that cycle), or when `cnt`==`MAX_BURST` (the sample is still taken that cycle).
  - Otherwise `cnt`++ and stay in GRANT.
- GRANT -> GAP transition:
  - `gnt` clears to 0.
  - `ptr` <= `sel`+1 mod 16 (wraps 15 -> 0).
  - `sel` holds its value.
- GAP: exactly one dead cycle with `gnt`=0 so the mux settles and the requester sees its grant drop. Always goes to IDLE.
- Fairness: a continuously requesting agent cannot win again until every other requesting agent has been served once.
- Requests arriving during GRANT or GAP are only considered in IDLE.
- Reset (asynchronous, any state including mid-burst):
  - State -> IDLE.
  - `sel`=0, `gnt`=0, `ptr`=0, `cnt`=0.
  - `busy`=0, `sample_valid`=0, `sample_data`=0, `sample_src`=0.
  - A partially taken sample is discarded.

## Timing
- Request to grant:
  - `req` sampled high in IDLE at edge k makes `gnt`/`sel` valid after edge k.
  - The first GRANT cycle is k..k+1.
- Sample latency:
  - `mux_out` is sampled at the end of each GRANT cycle.
  - `sample_valid` is high in the following cycle only (one cycle per captured bit, no gaps within a burst).
- Burst cost: one requester with `req` held high occupies IDLE(1) + GRANT(`MAX_BURST`) + GAP(1) cycles and yields `MAX_BURST` samples.
- Back-to-back service: minimum turnaround between the last GRANT cycle of one requester and the first GRANT cycle of the next is 2 cycles (GAP, IDLE).
- `busy` is the registered state==GRANT flag; it is equal to `|gnt`.
- Simultaneous events:
  - Dropping `req[sel]` in the same cycle the burst limit is reached: treat as a request drop, so no sample is taken that cycle.
  - A simultaneous set bit at `ptr` wins over all others.

## Test plan
- Reset and idle: `rst_n`=0, then release with `req`=0 for 10 cycles -> every output stays 0 and the state stays IDLE.
- Single burst: `MAX_BURST`=4, `req`=16'h0001 held, `mux_out` tied 1 -> `gnt`=16'h0001 and `sel`=0 for 4 cycles; 4 samples with data=1 and src=0; then GAP; `ptr`=1.
- Round-robin wrap:
  - Stimulus: `req`=16'h8003 held, reset `ptr`=0.
  - Response: grant order is 0, 1, 15, 0, 1, 15, …
  - Each burst yields 4 samples, and `sample_src` matches the order.
- Early drop:
  - Stimulus: `req`=16'h0020; drop `req[5]` in the 2nd GRANT cycle.
  - Response: exactly 1 sample with src=5; GRANT -> GAP; `ptr`=6.
- Mux datapath:
  - Stimulus: drive the mux `data` bus as a one-hot walk (bit i set when `sel`=i); `req`=16'hFFFF.
  - Response: every sample has data=1 and src cycles 0..15 in order, with 4 samples each.
- Reset mid-burst: assert `rst_n`=0 in the 3rd GRANT cycle of requester 7 -> `gnt`, `sel`, `busy` and `sample_valid` clear immediately; after release with `req` held, requester 0 (`ptr`=0) is granted first if requesting.
